// File: rtl/fpga_io_pkg.sv
// Shared configuration layout for the IO bank: per-pad config width,
// bit positions inside a pad's config word, and the config word type.
package fpga_io_pkg;

  localparam int CFG_W       = 4;
  localparam int CFG_OE      = 0;
  localparam int CFG_IN_REG  = 1;
  localparam int CFG_OUT_REG = 2;
  localparam int CFG_INV     = 3;

  typedef logic [CFG_W-1:0] io_cfg_t;

endpackage

// File: rtl/fpga_io_cell.sv
// One pad's datapath: optional polarity inversion and optional registering on
// both directions. Optional feature macro: FPGA_IO_SYNC_EN (2-flop input synchroniser).
module fpga_io_cell
  import fpga_io_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  io_cfg_t cfg,
  input  logic    fab_in,
  input  logic    pad_in,
  output logic    fab_out,
  output logic    pad_out,
  output logic    pad_oe
);

  logic in_src;
  logic in_val;
  logic out_val;
  logic in_q;
  logic out_q;

`ifdef FPGA_IO_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
    end
  end

  assign in_src = sync2;
`else
  assign in_src = pad_in;
`endif

  assign out_val = fab_in ^ cfg[CFG_INV];
  assign in_val  = in_src ^ cfg[CFG_INV];

  // Pipeline registers run regardless of config so a mode switch sees fresh data.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q  <= 1'b0;
      out_q <= 1'b0;
    end else begin
      in_q  <= in_val;
      out_q <= out_val;
    end
  end

  assign pad_out = cfg[CFG_OUT_REG] ? out_q : out_val;
  assign fab_out = cfg[CFG_IN_REG] ? in_q : in_val;
  assign pad_oe  = cfg[CFG_OE];

endmodule

// File: rtl/fpga_io_bank.sv
// Scan-configured IO bank: staging chain, length-checked commit into the active
// config, and one fpga_io_cell per pad. Optional feature macro: FPGA_IO_SYNC_EN.
module fpga_io_bank
  import fpga_io_pkg::*;
#(
  parameter int NUM_IO = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_in,
  input  logic              scan_en,
  output logic              scan_out,
  input  logic              cfg_commit,
  output logic              cfg_valid,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] fab_in,
  output logic [NUM_IO-1:0] fab_out,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oe
);

  localparam int L     = NUM_IO * CFG_W;
  localparam int CNT_W = $clog2(L + 2);

  logic [L-1:0]     sreg;
  logic [L-1:0]     active;
  logic [CNT_W-1:0] cnt;

  // The counter saturates one past L so an over-long load can never alias to L.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg      <= '0;
      active    <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (scan_en) begin
      sreg <= {scan_in, sreg[L-1:1]};
      if (cnt != CNT_W'(L + 1)) cnt <= cnt + CNT_W'(1);
      if (cfg_commit) cfg_err <= 1'b1;
    end else if (cfg_commit) begin
      cnt <= '0;
      if (cnt == CNT_W'(L)) begin
        active    <= sreg;
        cfg_valid <= 1'b1;
        cfg_err   <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  assign scan_out = sreg[0];

  for (genvar i = 0; i < NUM_IO; i++) begin : g_cell
    fpga_io_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .cfg     (active[i*CFG_W +: CFG_W]),
      .fab_in  (fab_in[i]),
      .pad_in  (pad_in[i]),
      .fab_out (fab_out[i]),
      .pad_out (pad_out[i]),
      .pad_oe  (pad_oe[i])
    );
  end

endmodule

// File: tb/tb_fpga_io_bank.sv
// Directed self-checking bench for fpga_io_bank with hand-computed expectations.
// Honours FPGA_IO_SYNC_EN for the expected input-path latency.
module tb_fpga_io_bank;

  localparam int NUM_IO = 20;
  localparam int L      = 80;

`ifdef FPGA_IO_SYNC_EN
  localparam int IN_LAT = 3;
`else
  localparam int IN_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              scan_in;
  logic              scan_en;
  logic              scan_out;
  logic              cfg_commit;
  logic              cfg_valid;
  logic              cfg_err;
  logic [NUM_IO-1:0] fab_in;
  logic [NUM_IO-1:0] fab_out;
  logic [NUM_IO-1:0] pad_in;
  logic [NUM_IO-1:0] pad_out;
  logic [NUM_IO-1:0] pad_oe;

  int vectors     = 0;
  int miscompares = 0;

  fpga_io_bank #(.NUM_IO(NUM_IO)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_in    (scan_in),
    .scan_en    (scan_en),
    .scan_out   (scan_out),
    .cfg_commit (cfg_commit),
    .cfg_valid  (cfg_valid),
    .cfg_err    (cfg_err),
    .fab_in     (fab_in),
    .fab_out    (fab_out),
    .pad_in     (pad_in),
    .pad_out    (pad_out),
    .pad_oe     (pad_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // First bit shifted (data[0]) lands at chain bit 0 after L shifts.
  task automatic applyStimulus(input logic [L-1:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      scan_en = 1'b1;
      scan_in = data[i];
      tick(1);
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic commitCfg();
    cfg_commit = 1'b1;
    tick(1);
    cfg_commit = 1'b0;
  endtask

  logic [L-1:0] cfg_a;
  logic [L-1:0] cfg_b;
  logic [L-1:0] pattern;

  initial begin
    reset      = 1'b1;
    scan_in    = 1'b0;
    scan_en    = 1'b0;
    cfg_commit = 1'b0;
    fab_in     = '0;
    pad_in     = 20'hA5A5A;

    // Reset state and transparent input path
    applyReset();
    tick(3);
    checkOutput("rst_pad_oe", L'(pad_oe), L'(20'h0));
    checkOutput("rst_fab_out", L'(fab_out), L'(20'hA5A5A));
    checkOutput("rst_pad_out", L'(pad_out), L'(20'h0));
    checkOutput("rst_cfg_valid", L'(cfg_valid), L'(1'b0));
    checkOutput("rst_cfg_err", L'(cfg_err), L'(1'b0));
    checkOutput("rst_scan_out", L'(scan_out), L'(1'b0));

    // Pad 3 driven and inverted
    cfg_a = '0;
    cfg_a[3*4 +: 4] = 4'b1001;
    applyStimulus(cfg_a, L);
    commitCfg();
    fab_in = 20'h00008;
    #1;
    checkOutput("p3_cfg_valid", L'(cfg_valid), L'(1'b1));
    checkOutput("p3_cfg_err", L'(cfg_err), L'(1'b0));
    checkOutput("p3_pad_oe", L'(pad_oe), L'(20'h00008));
    checkOutput("p3_pad_out", L'(pad_out), L'(20'h00000));
    checkOutput("p3_fab_out", L'(fab_out), L'(20'hA5A52));

    // Short load is rejected and leaves active config alone
    applyStimulus({L{1'b1}}, L - 1);
    commitCfg();
    checkOutput("short_cfg_err", L'(cfg_err), L'(1'b1));
    checkOutput("short_pad_oe", L'(pad_oe), L'(20'h00008));
    checkOutput("short_cfg_valid", L'(cfg_valid), L'(1'b1));

    // Full load right after proves the counter was cleared
    cfg_b = cfg_a;
    cfg_b[0 +: 4] = 4'b0110;
    applyStimulus(cfg_b, L);
    commitCfg();
    checkOutput("full_cfg_err", L'(cfg_err), L'(1'b0));
    checkOutput("full_pad_oe", L'(pad_oe), L'(20'h00008));

    // Pad 0 registered both ways: step right after edge N
    fab_in = 20'h00000;
    tick(4);
    fab_in = 20'h00001;
    pad_in = 20'hA5A5B;
    #1;
    checkOutput("reg_pad_out_n", L'(pad_out[0]), L'(1'b0));
    checkOutput("reg_fab_out_n", L'(fab_out[0]), L'(1'b0));
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      checkOutput($sformatf("reg_pad_out_n%0d", k), L'(pad_out[0]), L'(1'b1));
      checkOutput($sformatf("reg_fab_out_n%0d", k), L'(fab_out[0]), L'(k >= IN_LAT));
    end

    // Commit during shift: shift happens, commit rejected
    checkOutput("sc_pre_scan_out", L'(scan_out), L'(cfg_b[0]));
    scan_en    = 1'b1;
    scan_in    = 1'b1;
    cfg_commit = 1'b1;
    tick(1);
    scan_en    = 1'b0;
    cfg_commit = 1'b0;
    checkOutput("sc_scan_out", L'(scan_out), L'(cfg_b[1]));
    checkOutput("sc_cfg_err", L'(cfg_err), L'(1'b1));
    checkOutput("sc_pad_oe", L'(pad_oe), L'(20'h00008));

    // Reset taken mid-shift
    scan_en = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset   = 1'b0;
    scan_en = 1'b0;
    scan_in = 1'b0;
    checkOutput("mid_rst_pad_oe", L'(pad_oe), L'(20'h0));
    checkOutput("mid_rst_cfg_valid", L'(cfg_valid), L'(1'b0));
    checkOutput("mid_rst_cfg_err", L'(cfg_err), L'(1'b0));
    checkOutput("mid_rst_scan_out", L'(scan_out), L'(1'b0));
    fab_in = 20'h12345;
    pad_in = 20'hA5A5A;
    tick(3);
    checkOutput("mid_rst_pad_out", L'(pad_out), L'(20'h12345));
    checkOutput("mid_rst_fab_out", L'(fab_out), L'(20'hA5A5A));
    commitCfg();
    checkOutput("mid_rst_discard_err", L'(cfg_err), L'(1'b1));
    checkOutput("mid_rst_discard_valid", L'(cfg_valid), L'(1'b0));

    // Scan-out order: first bit in comes out first
    pattern = 80'hDEAD_BEEF_0123_4567_89AB;
    applyStimulus(pattern, L);
    for (int j = 0; j < L; j++) begin
      checkOutput($sformatf("scan_out_bit%0d", j), L'(scan_out), L'(pattern[j]));
      scan_en = 1'b1;
      scan_in = 1'b0;
      tick(1);
    end
    scan_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
